// File: rtl/result_buf_pkg.sv
// Shared definitions for the result row buffer.
//   - Default geometry: 8 complex lanes x 64 bits per row, 16 row slots.
//   - FSM state encoding used by result_row_buffer.
package result_buf_pkg;

    localparam int ROW_W_DEF = 512;  // result row width in bits
    localparam int DEPTH_DEF = 16;   // number of row slots
    localparam int AW_DEF    = 4;    // slot index width, log2(DEPTH)

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/result_row_ram.sv
// Row slot storage for result_row_buffer: DEPTH x ROW_W, one write port and
// one registered read port.
//   clk      : rising-edge clock
//   we_i     : write strobe, wdata_i stored at waddr_i
//   waddr_i  : write slot index
//   wdata_i  : row to store
//   re_i     : read enable; rdata_o updates only when set, otherwise holds
//   raddr_i  : read slot index
//   rdata_o  : registered read data (one cycle after re_i)
module result_row_ram
    import result_buf_pkg::*;
#(
    parameter int ROW_W = ROW_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [ROW_W-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [ROW_W-1:0] rdata_o
);

    logic [ROW_W-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; whether a slot holds meaningful data is
    // tracked by the valid bits in the parent, which keeps this mappable to RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        // Read enable gives a hold-able output register for backpressure.
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/result_row_buffer.sv
// Collects result rows written out of order by the vXc multiply-subtract
// stage, then drains them in slot order over a valid/ready stream.
//   clk       : rising-edge clock
//   reset     : synchronous, active-low reset
//   start     : pulse that arms a new collection (IDLE/DONE only)
//   num_rows  : rows expected, sampled on start, clamped to DEPTH
//   wr_en     : row write strobe from producer
//   wr_addr   : row index from producer
//   wr_data   : result row from producer
//   finish_in : producer finished; collection ends at the next edge
//   rd_data   : drained row (zeros for a slot never written)
//   rd_valid  : rd_data holds a row
//   rd_ready  : consumer accepts the row
//   rd_last   : row num_rows-1
//   done      : drain complete, held until the next start
//   err       : sticky [0] address out of range, [1] late write, [2] missing row
module result_row_buffer
    import result_buf_pkg::*;
#(
    parameter int ROW_W = ROW_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AW:0]      num_rows,
    input  logic             wr_en,
    input  logic [31:0]      wr_addr,
    input  logic [ROW_W-1:0] wr_data,
    input  logic             finish_in,
    output logic [ROW_W-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             rd_last,
    output logic             done,
    output logic [2:0]       err
);

    state_e           state_q, state_d;
    logic [AW:0]      nrows_q, nrows_d;     // latched, clamped row count
    logic [AW:0]      ptr_q, ptr_d;         // next slot to fetch from the RAM
    logic [DEPTH-1:0] valid_q, valid_d;     // per-slot written flag
    logic [2:0]       err_q, err_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_last_q, rd_last_d;
    logic             row_ok_q, row_ok_d;   // presented slot was written

    logic             ram_we;
    logic             ram_re;
    logic [ROW_W-1:0] ram_rdata;
    logic [AW:0]      nrows_clamped;
    logic             addr_in_range;
    logic             handshake;
    logic             load;

    assign nrows_clamped = (num_rows > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_rows;
    assign addr_in_range = wr_addr < 32'(nrows_q);
    assign handshake     = rd_valid_q && rd_ready;
    // Output stage may take a new row when empty or when the current one leaves.
    assign load          = !rd_valid_q || rd_ready;

    // NOTE: every _d gets its hold value first so no path leaves a signal
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        nrows_d    = nrows_q;
        ptr_d      = ptr_q;
        valid_d    = valid_q;
        err_d      = err_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        row_ok_d   = row_ok_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                // Writes after the drain are late; writes in IDLE are silently dropped.
                if (wr_en && state_q == DONE) begin
                    err_d[1] = 1'b1;
                end
                if (start) begin
                    nrows_d = nrows_clamped;
                    ptr_d   = '0;
                    valid_d = '0;
                    err_d   = '0;
                    state_d = (nrows_clamped == '0) ? DONE : COLLECT;
                end
            end

            COLLECT: begin
                if (wr_en) begin
                    if (addr_in_range) begin
                        ram_we                     = 1'b1;
                        valid_d[wr_addr[AW-1:0]] = 1'b1;
                    end else begin
                        err_d[0] = 1'b1;
                    end
                end
                if (finish_in) begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                if (wr_en) begin
                    err_d[1] = 1'b1;
                end
                if (handshake && !row_ok_q) begin
                    err_d[2] = 1'b1;
                end
                if (load) begin
                    if (ptr_q < nrows_q) begin
                        ram_re     = 1'b1;
                        rd_valid_d = 1'b1;
                        rd_last_d  = (ptr_q == nrows_q - (AW+1)'(1));
                        row_ok_d   = valid_q[ptr_q[AW-1:0]];
                        ptr_d      = ptr_q + (AW+1)'(1);
                    end else begin
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                        row_ok_d   = 1'b0;
                        // All rows fetched: the row leaving now was the last one.
                        if (rd_valid_q) begin
                            state_d = DONE;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // Reset outranks any write or read in flight.
        if (!reset) begin
            ram_we = 1'b0;
            ram_re = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            nrows_q    <= '0;
            ptr_q      <= '0;
            valid_q    <= '0;
            err_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            row_ok_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            nrows_q    <= nrows_d;
            ptr_q      <= ptr_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            row_ok_q   <= row_ok_d;
        end
    end

    result_row_ram #(
        .ROW_W (ROW_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_addr[AW-1:0]),
        .wdata_i (wr_data),
        .re_i    (ram_re),
        .raddr_i (ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    // Unwritten slots read as zero; row_ok_q is clear after reset so rd_data is too.
    assign rd_data  = row_ok_q ? ram_rdata : '0;
    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign done     = (state_q == DONE);
    assign err      = err_q;

endmodule

// File: tb/tb_result_row_buffer.sv
// Directed bench for result_row_buffer: drain phases are described as
// per-cycle tables of {rd_ready, late write, expected outputs}.
module tb_result_row_buffer;

    localparam int ROW_W = 512;
    localparam logic [ROW_W-1:0] JUNK = {8{64'hDEAD_BEEF_DEAD_BEEF}};

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [4:0]       num_rows = '0;
    logic             wr_en = 1'b0;
    logic [31:0]      wr_addr = '0;
    logic [ROW_W-1:0] wr_data = '0;
    logic             finish_in = 1'b0;
    logic [ROW_W-1:0] rd_data;
    logic             rd_valid;
    logic             rd_ready = 1'b0;
    logic             rd_last;
    logic             done;
    logic [2:0]       err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    result_row_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_rows  (num_rows),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .finish_in (finish_in),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_last   (rd_last),
        .done      (done),
        .err       (err)
    );

    // One entry per drain cycle: inputs for that cycle and outputs expected in it.
    typedef struct {
        logic ready;
        logic wr;      // drive a junk write to wr_a this cycle
        int   wr_a;
        logic ev;      // expected rd_valid
        logic el;      // expected rd_last
        int   eidx;    // expected row id, -1 = all zeros
        logic ed;      // expected done
    } vec_t;

    vec_t tbl[$];

    function automatic logic [ROW_W-1:0] row(int i);
        logic [63:0] lane;
        lane = 64'h4000_0000_4000_0000 | 64'(i);
        return {8{lane}};
    endfunction

    task automatic check(input string name, input logic [ROW_W-1:0] act,
                         input logic [ROW_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_coll(input int n);
        start    = 1'b1;
        num_rows = 5'(n);
        tick();
        start    = 1'b0;
    endtask

    task automatic write_row(input int a, input logic [ROW_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = 32'(a);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic finish();
        finish_in = 1'b1;
        tick();
        finish_in = 1'b0;
    endtask

    task automatic push_vec(input logic ready, input logic wr, input int wr_a,
                            input logic ev, input logic el, input int eidx,
                            input logic ed);
        vec_t v;
        v = '{ready, wr, wr_a, ev, el, eidx, ed};
        tbl.push_back(v);
    endtask

    task automatic run_table(input string tag);
        logic [ROW_W-1:0] exp_row;
        foreach (tbl[k]) begin
            rd_ready = tbl[k].ready;
            wr_en    = tbl[k].wr;
            wr_addr  = 32'(tbl[k].wr_a);
            wr_data  = JUNK;
            check($sformatf("%s[%0d] rd_valid", tag, k), ROW_W'(rd_valid), ROW_W'(tbl[k].ev));
            check($sformatf("%s[%0d] done", tag, k), ROW_W'(done), ROW_W'(tbl[k].ed));
            if (tbl[k].ev) begin
                exp_row = (tbl[k].eidx < 0) ? '0 : row(tbl[k].eidx);
                check($sformatf("%s[%0d] rd_last", tag, k), ROW_W'(rd_last), ROW_W'(tbl[k].el));
                check($sformatf("%s[%0d] rd_data", tag, k), rd_data, exp_row);
            end
            tick();
        end
        wr_en = 1'b0;
        tbl.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        bit seen_done;

        // ---- reset state ----
        tick();
        tick();
        check("reset rd_valid", ROW_W'(rd_valid), '0);
        check("reset rd_last",  ROW_W'(rd_last),  '0);
        check("reset done",     ROW_W'(done),     '0);
        check("reset err",      ROW_W'(err),      '0);
        check("reset rd_data",  rd_data,          '0);
        reset = 1'b1;
        tick();

        // ---- nominal: 4 rows, a start during COLLECT must be ignored ----
        start_coll(4);
        write_row(0, row(0));
        start = 1'b1; num_rows = 5'd1;
        write_row(1, row(1));
        start = 1'b0;
        write_row(2, row(2));
        write_row(3, row(3));
        finish();
        push_vec(1, 0, 0, 0, 0, 0, 0);
        push_vec(1, 0, 0, 1, 0, 0, 0);
        push_vec(1, 0, 0, 1, 0, 1, 0);
        push_vec(1, 0, 0, 1, 0, 2, 0);
        push_vec(1, 0, 0, 1, 1, 3, 0);
        push_vec(1, 0, 0, 0, 0, 0, 1);
        run_table("nominal");
        check("nominal done held", ROW_W'(done), ROW_W'(1));
        check("nominal err",       ROW_W'(err),  '0);

        // ---- backpressure: ready 1,0,0,1 across the rows ----
        start_coll(4);
        for (int i = 0; i < 4; i++) write_row(i, row(i));
        finish();
        push_vec(1, 0, 0, 0, 0, 0, 0);
        push_vec(1, 0, 0, 1, 0, 0, 0);
        push_vec(0, 0, 0, 1, 0, 1, 0);
        push_vec(0, 0, 0, 1, 0, 1, 0);
        push_vec(1, 0, 0, 1, 0, 1, 0);
        push_vec(1, 0, 0, 1, 0, 2, 0);
        push_vec(0, 0, 0, 1, 1, 3, 0);
        push_vec(1, 0, 0, 1, 1, 3, 0);
        push_vec(1, 0, 0, 0, 0, 0, 1);
        run_table("bp");
        check("bp err", ROW_W'(err), '0);

        // ---- boundaries: slot 2 missing, address 7 out of range ----
        start_coll(4);
        write_row(0, row(0));
        write_row(1, row(1));
        write_row(3, row(3));
        write_row(7, JUNK);
        check("oor err0", ROW_W'(err), ROW_W'(3'b001));
        finish();
        push_vec(1, 0, 0, 0, 0, 0, 0);
        push_vec(1, 0, 0, 1, 0, 0, 0);
        push_vec(1, 0, 0, 1, 0, 1, 0);
        push_vec(1, 0, 0, 1, 0, -1, 0);
        push_vec(1, 0, 0, 1, 1, 3, 0);
        push_vec(1, 0, 0, 0, 0, 0, 1);
        run_table("bound");
        check("bound err", ROW_W'(err), ROW_W'(3'b101));

        // ---- simultaneous: write with finish_in, late write during DRAIN ----
        start_coll(4);
        for (int i = 0; i < 3; i++) write_row(i, row(i));
        wr_en = 1'b1; wr_addr = 32'd3; wr_data = row(3); finish_in = 1'b1;
        tick();
        wr_en = 1'b0; finish_in = 1'b0;
        push_vec(1, 0, 0, 0, 0, 0, 0);
        push_vec(1, 1, 3, 1, 0, 0, 0);
        push_vec(1, 0, 0, 1, 0, 1, 0);
        push_vec(1, 0, 0, 1, 0, 2, 0);
        push_vec(1, 0, 0, 1, 1, 3, 0);
        push_vec(1, 0, 0, 0, 0, 0, 1);
        run_table("simul");
        check("simul err", ROW_W'(err), ROW_W'(3'b010));

        // ---- reset mid-DRAIN after 2 rows, then a clean 2-row run ----
        start_coll(4);
        for (int i = 0; i < 4; i++) write_row(i, row(i));
        finish();
        push_vec(1, 0, 0, 0, 0, 0, 0);
        push_vec(1, 0, 0, 1, 0, 0, 0);
        push_vec(1, 0, 0, 1, 0, 1, 0);
        run_table("pre_rst");
        check("pre_rst row2 shown", rd_data, row(2));
        reset = 1'b0;
        tick();
        check("rst rd_valid", ROW_W'(rd_valid), '0);
        check("rst done",     ROW_W'(done),     '0);
        check("rst rd_last",  ROW_W'(rd_last),  '0);
        check("rst rd_data",  rd_data,          '0);
        check("rst err",      ROW_W'(err),      '0);
        reset = 1'b1;
        write_row(0, JUNK);  // IDLE: dropped with no flag
        check("idle write err", ROW_W'(err),  '0);
        check("idle done",      ROW_W'(done), '0);
        start_coll(2);
        write_row(0, row(8));
        write_row(1, row(9));
        finish();
        push_vec(1, 0, 0, 0, 0, 0, 0);
        push_vec(1, 0, 0, 1, 0, 8, 0);
        push_vec(1, 0, 0, 1, 1, 9, 0);
        push_vec(1, 0, 0, 0, 0, 0, 1);
        run_table("post_rst");
        check("post_rst err", ROW_W'(err), '0);

        // ---- num_rows = 0 goes straight to DONE from a fresh start ----
        write_row(0, JUNK);  // DONE: late write sets err[1], cleared by start
        check("done late err", ROW_W'(err), ROW_W'(3'b010));
        start_coll(0);
        check("zero done",     ROW_W'(done),     ROW_W'(1));
        check("zero rd_valid", ROW_W'(rd_valid), '0);
        check("zero err",      ROW_W'(err),      '0);
        tick();
        check("zero rd_valid 2", ROW_W'(rd_valid), '0);

        // ---- num_rows = 20 clamps to 16 slots ----
        start_coll(20);
        for (int i = 0; i < 16; i++) write_row(i, row(20 + i));
        write_row(16, JUNK);
        check("clamp oor err", ROW_W'(err), ROW_W'(3'b001));
        finish();
        rd_ready  = 1'b1;
        cnt       = 0;
        seen_done = 1'b0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            if (done) begin
                seen_done = 1'b1;
            end else begin
                if (rd_valid) begin
                    check($sformatf("clamp row%0d data", cnt), rd_data, row(20 + cnt));
                    check($sformatf("clamp row%0d last", cnt), ROW_W'(rd_last),
                          ROW_W'(cnt == 15));
                    cnt++;
                end
                tick();
            end
        end
        check("clamp done reached", ROW_W'(seen_done), ROW_W'(1));
        check("clamp row count",    ROW_W'(cnt),       ROW_W'(16));
        check("clamp err",          ROW_W'(err),       ROW_W'(3'b001));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/result_row_buffer.md
RESULT_ROW_BUFFER -- requirements
Module: result_row_buffer

Interface
REQ-001 SHALL have parameter ROW_W, default 512, meaning result row width (8 complex lanes x 64 bits).
REQ-002 SHALL have parameter DEPTH, default 16, meaning number of row slots.
REQ-003 SHALL have parameter AW, default 4, meaning slot index width (log2 DEPTH).
REQ-004 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-006 SHALL have port start  input  1  one-cycle pulse that arms a new collection.
REQ-007 SHALL have port num_rows  input  AW+1  rows expected, sampled on start.
REQ-008 SHALL have port wr_en  input  1  row-write strobe from the vXc multiply-subtract stage (its result_mem_we).
REQ-009 SHALL have port wr_addr  input  32  row index from that stage (its counter3).
REQ-010 SHALL have port wr_data  input  ROW_W  result row (its vXc_add_8_output).
REQ-011 SHALL have port finish_in  input  1  producer finish level.
REQ-012 SHALL have port rd_data  output  ROW_W  drained row.
REQ-013 SHALL have ports rd_valid (output, 1), rd_ready (input, 1) and rd_last (output, 1): valid/ready stream, with rd_last marking the final row.
REQ-014 SHALL have port done  output  1  drain complete.
REQ-015 SHALL have port err  output  3  sticky flags: [0] address out of range, [1] late write, [2] missing row.

Function
REQ-016 SHALL implement FSM states IDLE, COLLECT, DRAIN and DONE.
REQ-017 SHALL, in IDLE or DONE, on start, latch num_rows, clear all slot-valid bits and err, deassert done, and go to COLLECT; num_rows=0 SHALL go directly to DONE; num_rows>DEPTH SHALL be clamped to DEPTH.
REQ-018 SHALL ignore start while in COLLECT or DRAIN.
REQ-019 SHALL, in COLLECT, on wr_en with wr_addr<latched num_rows, store wr_data in slot wr_addr[AW-1:0] and set that slot's valid bit; a rewrite of the same slot SHALL overwrite it with no flag.
REQ-020 SHALL, in COLLECT, on wr_en with wr_addr>=latched num_rows, drop the write and set err[0].
REQ-021 SHALL, in COLLECT with finish_in=1, go to DRAIN at the next edge, and a wr_en in that same cycle SHALL still be stored.
REQ-022 SHALL, in DRAIN, DONE or IDLE, drop any wr_en and set err[1] (IDLE: no flag).
REQ-023 SHALL, in DRAIN, present slots 0..num_rows-1 in ascending order, with rd_valid first asserted the cycle after entering DRAIN.
REQ-024 SHALL hold rd_data, rd_valid and rd_last stable while rd_valid=1 and rd_ready=0.
REQ-025 SHALL complete a transfer when rd_valid and rd_ready are both 1, presenting the next row in the following cycle (1 row/cycle throughput with rd_ready held high).
REQ-026 SHALL, for a slot whose valid bit is clear, output all zeros and set err[2] at the handshake of that slot.
REQ-027 SHALL assert rd_last only with the row num_rows-1.
REQ-028 SHALL, after the last handshake, drop rd_valid and enter DONE, with done=1 from the next cycle until the next start.
REQ-029 SHALL keep err sticky until start or reset.

Reset
REQ-030 SHALL, on reset=0 at a clock edge: state=IDLE, rd_valid=0, rd_last=0, done=0, err=0, all valid bits cleared, rd_data=0, latched num_rows=0.
REQ-031 SHALL, on reset mid-COLLECT or mid-DRAIN, abandon the transfer without finishing the in-flight row; slot data contents need not be cleared.
REQ-032 SHALL give reset priority over start, wr_en and the handshake.

Structure
REQ-033 SHALL place ROW_W, DEPTH, AW defaults and the FSM state encoding in shared package result_buf_pkg.
REQ-034 SHALL place slot storage in one sub-module, result_row_ram (1 write port, 1 registered read port, DEPTH x ROW_W); the valid bits, FSM and read pointer stay in result_row_buffer.

Verification
REQ-035 SHALL cover nominal flow: start with num_rows=4; write addresses 0..3 with rows 0x4000000040000000 replicated; finish_in; rd_ready=1 -> 4 consecutive rows in order, rd_last on the 4th, done=1 one cycle later, err=000.
REQ-036 SHALL cover backpressure: the same flow with rd_ready toggled 1,0,0,1 -> rd_data stable during stalls, no row lost or duplicated.
REQ-037 SHALL cover boundaries: num_rows=4, write addresses 0,1,3 plus address 7 -> err[0]=1; slot 2 drains as zero and err[2]=1.
REQ-038 SHALL cover simultaneous events: wr_en for slot 3 in the same cycle finish_in rises -> slot 3 stored; a wr_en during DRAIN -> dropped, err[1]=1.
REQ-039 SHALL cover reset mid-DRAIN after 2 rows -> next cycle rd_valid=0, done=0, state IDLE; a new start with num_rows=2 works cleanly.
REQ-040 SHALL cover num_rows=0 -> done=1 with no rd_valid; num_rows=20 -> clamped to 16 rows.
